// File: rtl/vec_pe.sv
// -----------------------------------------------------------------------------
// vec_pe -- vector processing element
//
// Computes LANES signed neuron x weight products per accepted beat, reduces
// them with a balanced adder tree and accumulates the beat sums over a
// sequence framed by ctl[0] (first) and ctl[1] (last). The finished dot
// product is presented on a registered result port with valid/ready
// handshaking. A single global enable stalls the whole pipeline when the
// result register is full and not being consumed.
//
// Pipeline: S1 product register -> S2 adder-tree register -> S3 accumulator
//           and result register (3-edge latency from accept to vld_o).
//
// Parameters:
//   DW     signed element width of neuron and weight
//   LANES  parallel multipliers per beat (>= 1)
//   ACC_W  accumulator / result width (>= 2*DW + $clog2(LANES))
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   neuron  in   LANES*DW packed signed neurons, lane i at [i*DW +: DW]
//   weight  in   LANES*DW packed signed weights, same packing
//   vld_i   in   input beat valid
//   ctl     in   ctl[0]=first (restart accumulation), ctl[1]=last (emit)
//   rdy_o   out  input ready; beat accepted when vld_i & rdy_o
//   result  out  ACC_W signed accumulated dot product
//   len_o   out  number of beats contained in result (saturates at 16'hFFFF)
//   sat_o   out  result was clamped (saturation build only, else 0)
//   vld_o   out  result valid
//   rdy_i   in   downstream ready; result consumed when vld_o & rdy_i
//
// Build option:
//   VEC_PE_SAT_EN  when defined, every accumulation clamps to the ACC_W
//                  signed range and a sticky per-sequence flag is reported
//                  on sat_o. When undefined, the accumulator wraps.
// -----------------------------------------------------------------------------
module vec_pe #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int ACC_W = 40
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*DW-1:0]    neuron,
    input  logic [LANES*DW-1:0]    weight,
    input  logic                   vld_i,
    input  logic [1:0]             ctl,
    output logic                   rdy_o,
    output logic [ACC_W-1:0]       result,
    output logic [15:0]            len_o,
    output logic                   sat_o,
    output logic                   vld_o,
    input  logic                   rdy_i
);

    localparam int PW    = 2 * DW;
    localparam int SUM_W = 2 * DW + $clog2(LANES);
    localparam int LVL   = $clog2(LANES);
    localparam int NP    = 1 << LVL;   // lanes padded to a power of two

    // ------------------------------------------------------------------
    // Global enable: everything advances unless a held result blocks it.
    // ------------------------------------------------------------------
    logic w_en;
    logic r_vld_o;

    assign w_en  = ~r_vld_o | rdy_i;
    assign rdy_o = w_en;

    // ------------------------------------------------------------------
    // S1: per-lane multipliers
    // ------------------------------------------------------------------
    logic [LANES*PW-1:0] w_prod_flat;
    logic [LANES*PW-1:0] r_prod_flat;
    logic                r_s1_vld;
    logic [1:0]          r_s1_ctl;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_prod_flat[gi*PW +: PW] =
                $signed(neuron[gi*DW +: DW]) * $signed(weight[gi*DW +: DW]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_flat <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_ctl    <= 2'b00;
        end else if (w_en) begin
            r_prod_flat <= w_prod_flat;
            r_s1_vld    <= vld_i;
            r_s1_ctl    <= ctl;
        end
    end

    // ------------------------------------------------------------------
    // S2: balanced adder tree stored as a heap (node k has children
    // 2k+1 and 2k+2; leaves occupy NP-1 .. 2*NP-2, root is node 0).
    // Padding leaves beyond LANES are zero.
    // ------------------------------------------------------------------
    logic [(2*NP-1)*SUM_W-1:0] w_tree;

    generate
        for (gi = 0; gi < NP; gi++) begin : g_leaf
            if (gi < LANES) begin : g_used
                assign w_tree[(NP-1+gi)*SUM_W +: SUM_W] =
                    SUM_W'($signed(r_prod_flat[gi*PW +: PW]));
            end else begin : g_pad
                assign w_tree[(NP-1+gi)*SUM_W +: SUM_W] = '0;
            end
        end
        for (gi = 0; gi < NP - 1; gi++) begin : g_node
            assign w_tree[gi*SUM_W +: SUM_W] =
                w_tree[(2*gi+1)*SUM_W +: SUM_W] + w_tree[(2*gi+2)*SUM_W +: SUM_W];
        end
    endgenerate

    logic signed [SUM_W-1:0] r_sum;
    logic                    r_s2_vld;
    logic [1:0]              r_s2_ctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum    <= '0;
            r_s2_vld <= 1'b0;
            r_s2_ctl <= 2'b00;
        end else if (w_en) begin
            r_sum    <= $signed(w_tree[0 +: SUM_W]);
            r_s2_vld <= r_s1_vld;
            r_s2_ctl <= r_s1_ctl;
        end
    end

    // ------------------------------------------------------------------
    // S3: accumulate
    // ------------------------------------------------------------------
    logic                    w_first;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_sum_ext;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_next;
    logic [15:0]             w_cnt_next;

    logic signed [ACC_W-1:0] r_acc;
    logic [15:0]             r_cnt;
    logic [ACC_W-1:0]        r_result;
    logic [15:0]             r_len;

    assign w_first   = r_s2_ctl[0];
    assign w_last    = r_s2_ctl[1];
    assign w_sum_ext = ACC_W'(r_sum);
    assign w_base    = w_first ? '0 : r_acc;

    // Beat counter restarts on first and sticks at all-ones.
    assign w_cnt_next = w_first ? 16'd1 :
                        ((r_cnt == 16'hFFFF) ? 16'hFFFF : r_cnt + 16'd1);

`ifdef VEC_PE_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] w_wide;
    logic                  w_clamp;
    logic                  w_flag_next;
    logic                  r_flag;
    logic                  r_sat;

    // One guard bit exposes overflow: the top two bits disagree.
    assign w_wide      = {w_base[ACC_W-1], w_base} + {w_sum_ext[ACC_W-1], w_sum_ext};
    assign w_clamp     = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign w_next      = w_clamp ? (w_wide[ACC_W] ? ACC_MIN : ACC_MAX)
                                 : w_wide[ACC_W-1:0];
    assign w_flag_next = (w_first ? 1'b0 : r_flag) | w_clamp;
    assign sat_o       = r_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
            r_sat  <= 1'b0;
        end else if (w_en && r_s2_vld) begin
            if (w_last) begin
                r_sat  <= w_flag_next;
                r_flag <= 1'b0;
            end else begin
                r_flag <= w_flag_next;
            end
        end
    end
`else
    assign w_next = w_base + w_sum_ext;
    assign sat_o  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_len    <= '0;
            r_vld_o  <= 1'b0;
        end else if (w_en) begin
            if (r_s2_vld && w_last) begin
                // Emit and clear so a following beat without first
                // starts from zero.
                r_result <= w_next;
                r_len    <= w_cnt_next;
                r_vld_o  <= 1'b1;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                // en with vld_o high implies rdy_i: any old result is
                // consumed this edge.
                r_vld_o <= 1'b0;
                if (r_s2_vld) begin
                    r_acc <= w_next;
                    r_cnt <= w_cnt_next;
                end
            end
        end
    end

    assign result = r_result;
    assign len_o  = r_len;
    assign vld_o  = r_vld_o;

endmodule

// File: tb/tb_vec_pe.sv
module tb_vec_pe;

    localparam int DW    = 16;
    localparam int LANES = 4;
    localparam int ACC_W = 40;

    logic                clk;
    logic                rst_n;
    logic [LANES*DW-1:0] neuron;
    logic [LANES*DW-1:0] weight;
    logic                vld_i;
    logic [1:0]          ctl;
    logic                rdy_o;
    logic [ACC_W-1:0]    result;
    logic [15:0]         len_o;
    logic                sat_o;
    logic                vld_o;
    logic                rdy_i;

    vec_pe #(.DW(DW), .LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .neuron (neuron),
        .weight (weight),
        .vld_i  (vld_i),
        .ctl    (ctl),
        .rdy_o  (rdy_o),
        .result (result),
        .len_o  (len_o),
        .sat_o  (sat_o),
        .vld_o  (vld_o),
        .rdy_i  (rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint res;
        longint len;
        longint sat;
    } exp_t;

    exp_t   exp_q[$];
    longint m_acc  = 0;
    longint m_cnt  = 0;
    bit     m_flag = 0;

    int     nv[LANES];
    int     wv[LANES];

    longint last_res = 0;
    longint last_len = 0;
    longint last_sat = 0;
    int     pops     = 0;
    bit     rand_rdy = 0;
    bit     accepted = 0;

    localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

    function automatic longint wrap_acc(input longint v);
        longint t;
        t = v <<< (64 - ACC_W);
        return t >>> (64 - ACC_W);
    endfunction

    // Dot product of the beat, then accumulate with plain integer math.
    task automatic model_beat(input logic [1:0] c);
        longint s;
        longint nxt;
        bit     clamp;
        exp_t   e;
        s = 0;
        for (int i = 0; i < LANES; i++) s += longint'(nv[i]) * longint'(wv[i]);
        nxt   = (c[0] ? 0 : m_acc) + s;
        clamp = 0;
`ifdef VEC_PE_SAT_EN
        if (nxt > MAXV) begin nxt = MAXV; clamp = 1; end
        else if (nxt < MINV) begin nxt = MINV; clamp = 1; end
`else
        nxt = wrap_acc(nxt);
`endif
        m_cnt  = c[0] ? 1 : ((m_cnt >= 65535) ? 65535 : m_cnt + 1);
        m_flag = (c[0] ? 1'b0 : m_flag) | clamp;
        if (c[1]) begin
            e.res = nxt;
            e.len = m_cnt;
            e.sat = m_flag;
            exp_q.push_back(e);
            m_acc  = 0;
            m_cnt  = 0;
            m_flag = 0;
        end else begin
            m_acc = nxt;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc  = 0;
        m_cnt  = 0;
        m_flag = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_vec();
        for (int i = 0; i < LANES; i++) begin
            neuron[i*DW +: DW] = nv[i][DW-1:0];
            weight[i*DW +: DW] = wv[i][DW-1:0];
        end
    endtask

    task automatic set_std();
        for (int i = 0; i < LANES; i++) begin
            nv[i] = i + 1;
            wv[i] = i + 5;
        end
    endtask

    task automatic set_rand();
        logic [15:0] t;
        for (int i = 0; i < LANES; i++) begin
            t = 16'($urandom);
            nv[i] = int'($signed(t));
            t = 16'($urandom);
            wv[i] = int'($signed(t));
        end
    endtask

    // Called just after a falling edge with inputs set; samples, scores,
    // then waits for the next falling edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (vld_o && rdy_i) begin
            last_res = longint'($signed(result));
            last_len = longint'(len_o);
            last_sat = longint'(sat_o);
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result", last_res, e.res);
                check("len", last_len, e.len);
                check("sat", last_sat, e.sat);
                $display("result %0d len %0d sat %0d", last_res, last_len, last_sat);
            end
            pops++;
        end
        accepted = vld_i && rdy_o;
        if (accepted) model_beat(ctl);
        @(negedge clk);
        if (rand_rdy) rdy_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [1:0] c);
        int k;
        drive_vec();
        ctl   = c;
        vld_i = 1'b1;
        k     = 0;
        do begin
            cycle();
            k++;
        end while (!accepted && k < 200);
        if (!accepted) check("accept_timeout", 0, 1);
        vld_i = 1'b0;
    endtask

    task automatic idle(input int n);
        vld_i = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic drain();
        int k;
        vld_i = 1'b0;
        k     = 0;
        while (exp_q.size() > 0 && k < 400) begin
            cycle();
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int p0;
        rst_n  = 1'b0;
        rdy_i  = 1'b1;
        vld_i  = 1'b0;
        ctl    = 2'b00;
        neuron = '0;
        weight = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_rdy_o", rdy_o, 1);
        check("rst_vld_o", vld_o, 0);
        check("rst_result", longint'(result), 0);
        check("rst_len", len_o, 0);
        check("rst_sat", sat_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single framed beat and latency
        set_std();
        drive_vec();
        ctl   = 2'b11;
        vld_i = 1'b1;
        cycle();
        vld_i = 1'b0;
        check("lat_e0", vld_o, 0);
        cycle();
        check("lat_e1", vld_o, 0);
        cycle();
        check("lat_e2", vld_o, 1);
        drain();
        check("dir_70", last_res, 70);
        check("dir_len1", last_len, 1);
        check("dir_sat0", last_sat, 0);

        // Three-beat sequence with a gap, then a negative single beat
        send_beat(2'b01);
        idle(2);
        send_beat(2'b00);
        send_beat(2'b10);
        drain();
        check("seq_210", last_res, 210);
        check("seq_len3", last_len, 3);
        for (int i = 0; i < LANES; i++) begin nv[i] = -1; wv[i] = 1; end
        send_beat(2'b11);
        drain();
        check("neg_4", last_res, -4);

        // Backpressure: hold a result, verify input stalls, then stream
        rdy_i = 1'b0;
        set_std();
        send_beat(2'b11);
        idle(3);
        check("stall_vld", vld_o, 1);
        set_rand();
        drive_vec();
        ctl   = 2'b01;
        vld_i = 1'b1;
        repeat (5) begin
            check("stall_rdy_o", rdy_o, 0);
            cycle();
            check("stall_no_accept", accepted, 0);
        end
        rdy_i = 1'b1;
        send_beat(2'b01);
        for (int b = 0; b < 8; b++) begin
            set_rand();
            send_beat(2'b00);
        end
        set_rand();
        send_beat(2'b10);
        drain();

        // Randomised traffic with random downstream ready
        rand_rdy = 1'b1;
        for (int b = 0; b < 300; b++) begin
            set_rand();
            send_beat(2'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        set_rand();
        send_beat(2'b10);
        drain();
        rand_rdy = 1'b0;
        rdy_i    = 1'b1;

        // Accumulator overflow boundary: 128 x 2^32 = 2^39
        for (int i = 0; i < LANES; i++) begin nv[i] = -32768; wv[i] = -32768; end
        for (int b = 0; b < 128; b++) send_beat({b == 127, b == 0});
        drain();
`ifdef VEC_PE_SAT_EN
        check("ovf_result", last_res, MAXV);
        check("ovf_sat", last_sat, 1);
`else
        check("ovf_result", last_res, MINV);
        check("ovf_sat", last_sat, 0);
`endif
        check("ovf_len128", last_len, 128);

        // Reset mid-sequence with beats in flight
        set_std();
        send_beat(2'b01);
        send_beat(2'b00);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld_o", vld_o, 0);
        check("mid_rst_result", longint'(result), 0);
        check("mid_rst_len", len_o, 0);
        check("mid_rst_sat", sat_o, 0);
        check("mid_rst_rdy_o", rdy_o, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(2'b11);
        drain();
        check("post_rst_70", last_res, 70);
        check("post_rst_len1", last_len, 1);

        // Back-to-back single-beat sequences: one result per cycle
        p0 = pops;
        for (int b = 0; b < 8; b++) begin
            set_rand();
            send_beat(2'b11);
        end
        idle(3);
        check("b2b_count", pops - p0, 8);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_pe.md
# vec_pe

Parametrised vector processing element for the DLP datapath: LANES signed neuron×weight products per beat, reduced by an adder tree and accumulated over a beat sequence delimited by first/last control. It generalises the single-lane serial PE to configurable data width, lane count and accumulator width. It adds explicit sequence framing, a registered result with valid/ready backpressure, a beat counter and optional saturation. The block sits between the neuron/weight buffers and the output collector.

## Interface
- DW, 16, signed element width of neuron and weight
- LANES, 4, parallel multipliers per beat (≥1)
- ACC_W, 40, accumulator/result width; must be ≥ SUM_W = 2·DW + $clog2(LANES)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- neuron  in  LANES·DW  packed signed neurons, lane i at [i·DW +: DW]
- weight  in  LANES·DW  packed signed weights, same packing
- vld_i  in  1  input beat valid
- ctl  in  2  ctl[0]=first (restart accumulation), ctl[1]=last (emit result)
- rdy_o  out  1  input ready; beat accepted when vld_i & rdy_o
- result  out  ACC_W  signed accumulated dot product
- len_o  out  16  beats contained in result
- sat_o  out  1  result was clamped (saturation build only)
- vld_o  out  1  result valid
- rdy_i  in  1  downstream ready; result consumed when vld_o & rdy_i

## Operation
- Global enable en = ~vld_o | rdy_i; rdy_o = en. All pipeline registers and valid bits advance only when en=1; otherwise everything holds.
- S1 (accept): per lane, product = neuron_i × weight_i, 2·DW signed, registered with valid and ctl.
- S2: adder tree sums LANES products sign-extended to SUM_W; registered with valid and ctl.
- S3 (accumulate), on a valid S2 beat:
  - next = (first ? 0 : acc) + sign-extended sum, in ACC_W.
  - cnt_next = first ? 1 : cnt+1, saturating at 16'hFFFF.
  - last=0: acc ← next, cnt ← cnt_next.
  - last=1: result ← next, len_o ← cnt_next, sat_o ← sticky saturation flag including this beat, vld_o ← 1; acc, cnt and flag ← 0.
  - first=last=1: single-beat result equals the sum.
  - Beat without first after a last starts from the cleared accumulator.
- Result register holds until consumed. A new result loads in the same cycle an old one is consumed (vld_o & rdy_i).
- Invalid S2 slots leave acc/cnt unchanged; vld_i=0 gaps within a sequence are legal.
- Reset (any time, mid-sequence included): S1/S2 valids, acc, cnt, flag, result, len_o, sat_o, vld_o all 0; in-flight beats discarded.

## Timing
- Beat accepted at edge E0 → product registered E0, sum E1, accumulate E2; for a last beat, vld_o high from E2 (3-edge latency, no stall).
- Throughput one beat per cycle while rdy_i=1.
- rdy_o is combinational from vld_o and rdy_i; no combinational path from vld_i to any output.
- Reset values: rdy_o=1, vld_o=0, result=0, len_o=0, sat_o=0.

## Configuration
- VEC_PE_SAT_EN defined: each accumulation clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Any clamp within a sequence sets the sticky flag, reported on sat_o with the result.
- Undefined: two's-complement wrap in ACC_W; sat_o tied 0.

## Test plan
- DW=16, LANES=4: neuron {1,2,3,4}, weight {5,6,7,8}, ctl=2'b11 → vld_o 3 edges later, result=70, len_o=1, sat_o=0.
- Three beats of that vector, ctl 01,00,10 with a 2-cycle vld_i gap → single result=210, len_o=3. Next 2'b11 beat {−1,−1,−1,−1}×{1,1,1,1} → result=−4.
- Hold rdy_i=0 with a result pending while streaming 10 beats → rdy_o=0, no beat lost. All later results match the model in order after rdy_i=1.
- 128 beats, all lanes −32768×−32768 (sum 2^32), first/last framed:
  - SAT build: result=2^39−1, sat_o=1.
  - Non-SAT build: result=−2^39, sat_o=0.
  - Both builds: len_o=128.
- Assert rst_n low mid-sequence after 2 beats → all outputs 0 immediately. After release, a 2'b11 beat returns only its own sum.
- Back-to-back 2'b11 beats with rdy_i=1 → one result per cycle, each equal to its own beat's sum.
